// File: rtl/cpu_pkg.sv
// cpu_pkg: register-file and ROB definitions shared by dispatch, ROB and regfile_rename.
package cpu_pkg;
   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;
   localparam int ROB_TAG_W = 4;
   typedef struct packed {
      logic                 busy;
      logic [ROB_TAG_W-1:0] tag;
   } reg_status_t;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port with register-0 masking and commit bypass.
module regfile_rd_port import cpu_pkg::*; #(
   parameter int XLEN  = cpu_pkg::XLEN,
   parameter int IDX_W = cpu_pkg::REG_IDX_W,
   parameter int TAG_W = cpu_pkg::ROB_TAG_W
) (
   input  logic [IDX_W-1:0] idx_in,
   input  logic [XLEN-1:0]  val_in,
   input  logic             busy_in,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             cmt_en_in,
   input  logic [IDX_W-1:0] cmt_idx_in,
   input  logic [TAG_W-1:0] cmt_tag_in,
   input  logic [XLEN-1:0]  cmt_val_in,
   output logic [XLEN-1:0]  val_out,
   output logic             busy_out,
   output logic [TAG_W-1:0] tag_out
);
   logic zero, hit, retire;
   always_comb begin
      zero     = idx_in == '0;
      hit      = cmt_en_in && idx_in == cmt_idx_in;
      retire   = hit && busy_in && tag_in == cmt_tag_in;
      val_out  = zero ? '0 : hit ? cmt_val_in : val_in;
      busy_out = !zero && busy_in && !retire;
      tag_out  = busy_out ? tag_in : '0;
   end
endmodule

// File: rtl/regfile_rename.sv
// regfile_rename: committed register values plus per-register pending-producer (busy/tag) status.
module regfile_rename import cpu_pkg::*; #(
   parameter int XLEN  = cpu_pkg::XLEN,
   parameter int NREG  = 32,
   parameter int IDX_W = $clog2(NREG),
   parameter int TAG_W = cpu_pkg::ROB_TAG_W,
   parameter int NRD   = 2
) (
   input  logic                 clk_in,
   input  logic                 rst_n,
   input  logic                 rdy_in,
   input  logic [NRD*IDX_W-1:0] rd_idx_in,
   output logic [NRD*XLEN-1:0]  rd_val_out,
   output logic [NRD-1:0]       rd_busy_out,
   output logic [NRD*TAG_W-1:0] rd_tag_out,
   input  logic                 ren_valid_in,
   input  logic [IDX_W-1:0]     ren_idx_in,
   input  logic [TAG_W-1:0]     ren_tag_in,
   input  logic                 cmt_valid_in,
   input  logic [IDX_W-1:0]     cmt_idx_in,
   input  logic [TAG_W-1:0]     cmt_tag_in,
   input  logic [XLEN-1:0]      cmt_val_in,
   input  logic                 flush_in
);
   logic [XLEN-1:0]  val_q [NREG];
   logic [XLEN-1:0]  val_d [NREG];
   logic [TAG_W-1:0] tag_q [NREG];
   logic [TAG_W-1:0] tag_d [NREG];
   logic [NREG-1:0]  busy_q, busy_d;
   logic             cmt_en, ren_en, flush_en;
   // rst_n gates the commit so the bypass cannot leak a value while in reset
   assign cmt_en   = rst_n && rdy_in && cmt_valid_in && cmt_idx_in != '0;
   assign ren_en   = rdy_in && ren_valid_in && !flush_in && ren_idx_in != '0;
   assign flush_en = rdy_in && flush_in;
   always_comb begin
      val_d  = val_q;
      busy_d = busy_q;
      tag_d  = tag_q;
      if (cmt_en) begin
         val_d[cmt_idx_in] = cmt_val_in;
         if (busy_q[cmt_idx_in] && tag_q[cmt_idx_in] == cmt_tag_in) begin
            busy_d[cmt_idx_in] = 1'b0;
            tag_d[cmt_idx_in]  = '0;
         end
      end
      if (flush_en) begin
         busy_d = '0;
         tag_d  = '{default: '0};
      end else if (ren_en) begin
         busy_d[ren_idx_in] = 1'b1;
         tag_d[ren_idx_in]  = ren_tag_in;
      end
   end
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         val_q  <= '{default: '0};
         busy_q <= '0;
         tag_q  <= '{default: '0};
      end else begin
         val_q  <= val_d;
         busy_q <= busy_d;
         tag_q  <= tag_d;
      end
   end
   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [IDX_W-1:0] idx;
      assign idx = rd_idx_in[p*IDX_W +: IDX_W];
      regfile_rd_port #(.XLEN(XLEN), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_rd (
         .idx_in     (idx),
         .val_in     (val_q[idx]),
         .busy_in    (busy_q[idx]),
         .tag_in     (tag_q[idx]),
         .cmt_en_in  (cmt_en),
         .cmt_idx_in (cmt_idx_in),
         .cmt_tag_in (cmt_tag_in),
         .cmt_val_in (cmt_val_in),
         .val_out    (rd_val_out[p*XLEN +: XLEN]),
         .busy_out   (rd_busy_out[p]),
         .tag_out    (rd_tag_out[p*TAG_W +: TAG_W])
      );
   end
endmodule
